// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the multiplexed 7-segment display driver:
//   - segment bit positions (seg[0] = a ... seg[6] = g)
//   - the sixteen active-high hex glyphs (6 and 9 carry tails; b, d lowercase)
//   - scan FSM state encoding
// -----------------------------------------------------------------------------
package seg7_pkg;

    // Segment bit positions within the 7-bit segment bus
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-high glyphs indexed by nibble value
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F,  // 0
        7'h06,  // 1
        7'h5B,  // 2
        7'h4F,  // 3
        7'h66,  // 4
        7'h6D,  // 5
        7'h7D,  // 6 (top tail)
        7'h07,  // 7
        7'h7F,  // 8
        7'h6F,  // 9 (bottom tail)
        7'h77,  // A
        7'h7C,  // b
        7'h39,  // C
        7'h5E,  // d
        7'h79,  // E
        7'h71   // F
    };

    // Scan FSM states
    typedef enum logic {
        SCAN  = 1'b0,
        BLANK = 1'b1
    } scan_state_e;

    // Nibble to active-high segment pattern
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// -----------------------------------------------------------------------------
// seg7_hex_decoder
// Purely combinational hex nibble to 7-segment decoder.
// Ports:
//   nibble_i  in  4  hex value 0..F
//   seg_o     out 7  active-high segments, seg_o[0] = a ... seg_o[6] = g
// -----------------------------------------------------------------------------
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Table lookup of the glyph for the selected nibble
    always_comb begin
        seg_o = hex_to_seg(nibble_i);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed N-digit 7-segment driver with a double-buffered value.
// A load writes the pending buffer; the display buffer takes the pending value
// only at a frame boundary (or continuously while disabled), so a frame never
// shows a mixture of two values. Each digit is lit for CLK_DIV cycles followed
// by GAP all-off cycles. All outputs are registered.
// Ports:
//   clk         in   1           rising-edge clock
//   rst_n       in   1           asynchronous active-low reset
//   enable      in   1           display on
//   load        in   1           capture data_in/dp_in into the pending buffer
//   data_in     in   4*N_DIGITS  hex nibbles, digit 0 in [3:0]
//   dp_in       in   N_DIGITS    decimal point per digit
//   seg         out  7           segments a..g (polarity per ACTIVE_LOW_SEG)
//   dp          out  1           decimal point of the lit digit
//   dig         out  N_DIGITS    digit enables (polarity per ACTIVE_LOW_DIG)
//   frame_done  out  1           one-cycle pulse with the first cycle of a new frame
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int CLK_DIV        = 1000,
    parameter int GAP            = 2,
    parameter bit ACTIVE_LOW_SEG = 1'b1,
    parameter bit ACTIVE_LOW_DIG = 1'b1,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   data_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     dig,
    output logic                    frame_done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    // Inactive output levels
    localparam logic [6:0]          SEG_OFF = {7{ACTIVE_LOW_SEG}};
    localparam logic                DP_OFF  = ACTIVE_LOW_SEG;
    localparam logic [N_DIGITS-1:0] DIG_OFF = {N_DIGITS{ACTIVE_LOW_DIG}};

    // Buffers
    logic [4*N_DIGITS-1:0] pend_data_q, pend_data_d;
    logic [N_DIGITS-1:0]   pend_dp_q,   pend_dp_d;
    logic [4*N_DIGITS-1:0] disp_data_q, disp_data_d;
    logic [N_DIGITS-1:0]   disp_dp_q,   disp_dp_d;

    // Scan FSM and counters
    scan_state_e       state_q, state_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [GAP_W-1:0]  gap_q,   gap_d;
    logic              advance_s;
    logic              commit_s;

    // Commit happened on the previous edge; frame_done follows one cycle later
    // so it lines up with the first output cycle of digit 0.
    logic              fresh_q, fresh_d;

    // Output path
    logic [3:0]          nib_s;
    logic                dp_sel_s;
    logic                blank_sel_s;
    logic [N_DIGITS-1:0] zero_from_s;
    logic [6:0]          dec_seg_s;
    logic [6:0]          seg_on_s;
    logic                dp_on_s;
    logic [N_DIGITS-1:0] dig_on_s;

    logic [6:0]          seg_q, seg_d;
    logic                dp_q,  dp_d;
    logic [N_DIGITS-1:0] dig_q, dig_d;
    logic                frame_done_q, frame_done_d;

    // Buffer next-state: last load wins; display follows pending while off
    always_comb begin
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        disp_data_d = disp_data_q;
        disp_dp_d   = disp_dp_q;
        if (load) begin
            pend_data_d = data_in;
            pend_dp_d   = dp_in;
        end else begin
            pend_data_d = pend_data_q;
            pend_dp_d   = pend_dp_q;
        end
        // Display takes the pre-edge pending value, so a load on the commit
        // cycle is only seen at the next commit.
        if (!enable || commit_s) begin
            disp_data_d = pend_data_q;
            disp_dp_d   = pend_dp_q;
        end else begin
            disp_data_d = disp_data_q;
            disp_dp_d   = disp_dp_q;
        end
    end

    // Buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            disp_data_q <= '0;
            disp_dp_q   <= '0;
        end else begin
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            disp_data_q <= disp_data_d;
            disp_dp_q   <= disp_dp_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN;
            idx_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            fresh_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            fresh_q <= fresh_d;
        end
    end

    // FSM next-state: lit period, optional gap, then advance to next digit
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        advance_s = 1'b0;
        commit_s  = 1'b0;
        if (!enable) begin
            state_d = SCAN;
            idx_d   = '0;
            cnt_d   = '0;
            gap_d   = '0;
        end else begin
            case (state_q)
                SCAN: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (GAP > 0) begin
                            state_d = BLANK;
                        end else begin
                            advance_s = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                BLANK: begin
                    if (gap_q == GAP_LAST) begin
                        gap_d     = '0;
                        state_d   = SCAN;
                        advance_s = 1'b1;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_d = SCAN;
                    idx_d   = '0;
                    cnt_d   = '0;
                    gap_d   = '0;
                end
            endcase
            if (advance_s) begin
                if (idx_q == IDX_LAST) begin
                    idx_d    = '0;
                    commit_s = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end else begin
                idx_d = idx_q;
            end
        end
        fresh_d = enable && commit_s;
    end

    // Leading-zero map: bit i set when digits i..N-1 are all zero with no dp
    always_comb begin
        logic run_v;
        run_v       = 1'b1;
        zero_from_s = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            run_v          = run_v && (disp_data_q[4*i +: 4] == 4'h0) && !disp_dp_q[i];
            zero_from_s[i] = run_v;
        end
    end

    // Select nibble, dp and blanking flag of the current digit
    always_comb begin
        nib_s       = 4'h0;
        dp_sel_s    = 1'b0;
        blank_sel_s = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_s       = disp_data_q[4*i +: 4];
                dp_sel_s    = disp_dp_q[i];
                blank_sel_s = BLANK_LEADING && (i != 0) && zero_from_s[i];
            end else begin
                nib_s       = nib_s;
            end
        end
    end

    seg7_hex_decoder u_dec (
        .nibble_i (nib_s),
        .seg_o    (dec_seg_s)
    );

    // FSM output decode (active-high), polarity applied just before the flops
    always_comb begin
        seg_on_s = 7'h00;
        dp_on_s  = 1'b0;
        dig_on_s = '0;
        if (enable && (state_q == SCAN)) begin
            seg_on_s = blank_sel_s ? 7'h00 : dec_seg_s;
            dp_on_s  = dp_sel_s;
            for (int i = 0; i < N_DIGITS; i++) begin
                dig_on_s[i] = (idx_q == IDX_W'(i));
            end
        end else begin
            seg_on_s = 7'h00;
            dp_on_s  = 1'b0;
            dig_on_s = '0;
        end
        seg_d        = SEG_OFF ^ seg_on_s;
        dp_d         = DP_OFF ^ dp_on_s;
        dig_d        = DIG_OFF ^ dig_on_s;
        frame_done_d = fresh_q && enable;
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            dig_q        <= DIG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            dig_q        <= dig_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign dig        = dig_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed N-digit 7-segment display driver, the parametrised successor to the team's single-digit combinational decoder. Holds a double-buffered hex display value and time-multiplexes it onto a shared segment bus with per-digit enables, full 0–F decoding, decimal points, leading-zero blanking and an anti-ghosting blank gap. Sits between the register/control logic and the board's display pins; new values are applied only at frame boundaries, so the display never shows a torn value.

## Interface
- N_DIGITS, 4, number of digits, 1..16
- CLK_DIV, 1000, clock cycles each digit is lit, ≥1
- GAP, 2, all-off clock cycles between digits, ≥0
- ACTIVE_LOW_SEG, 1, 1 = segment and dp outputs are active-low
- ACTIVE_LOW_DIG, 1, 1 = digit enables are active-low
- BLANK_LEADING, 1, 1 = suppress leading zeros
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  display on
- load  in  1  single-cycle strobe: capture data_in/dp_in into the pending buffer
- data_in  in  4*N_DIGITS  hex nibbles; digit 0 = [3:0] = least significant
- dp_in  in  N_DIGITS  decimal point per digit
- seg  out  7  segments; seg[0]=a … seg[6]=g
- dp  out  1  decimal point of the lit digit
- dig  out  N_DIGITS  digit enables; dig[i] lights digit i
- frame_done  out  1  one-cycle pulse on each pending→display commit

## Operation
- Two value registers: pending (written by load) and display (drives outputs). Both reset to 0.
- load: pending ← {data_in, dp_in} on the same edge. Multiple loads before a commit: the last one wins.
- FSM states SCAN and BLANK; digit index idx, prescaler cnt ($clog2(CLK_DIV) bits, min 1); counter at CLK_DIV-1 is the terminal value.
- SCAN: digit idx lit; cnt increments; at CLK_DIV-1, cnt←0 and go to BLANK (GAP>0) or advance directly (GAP=0).
- BLANK: all digits off; runs GAP cycles, then advance.
- Advance: idx←idx+1; at idx=N_DIGITS-1, wrap to 0 and commit display←pending, frame_done=1.
- A load on the commit cycle lands in pending only; it is displayed at the following commit (no bypass).
- enable=0: dig all inactive, seg/dp inactive; FSM held at SCAN, idx=0, cnt=0; display←pending every cycle; frame_done stays 0. Scanning restarts at digit 0 on the cycle enable rises.
- Decode: standard hex, with 6/9 carrying tails and b,d lowercase; fixed encodings are in the package.
- Leading-zero blanking (BLANK_LEADING=1): digit i is blanked (seg off, dp still shown) when every digit j≥i has nibble 0 and dp 0. Digit 0 is never blanked. Evaluated on the display register.
- Polarity is applied only at the output registers.

## Timing
- Reset (asynchronous assert; release synchronised by the integrator): dig, seg and dp all inactive (all-ones when the corresponding ACTIVE_LOW parameter is 1); frame_done=0; FSM SCAN, idx=0, cnt=0.
- All outputs are registered and lag FSM state by 1 cycle. The first lit digit 0 appears 1 cycle after the first clk edge with rst_n=1 and enable=1.
- Each dig[i] is active for exactly CLK_DIV consecutive cycles, followed by GAP cycles with all digits off. Frame period = N_DIGITS*(CLK_DIV+GAP).
- At most one dig bit is active in any cycle. seg and dig change on the same edge.
- frame_done is high for 1 cycle, coincident with the first output cycle of digit 0 of the new frame. New display content is visible from that cycle.
- Reset mid-frame: immediate return to reset values; the pending value is lost.

## Structure
- Package seg7_pkg: the 16 hex segment encodings, segment bit-position constants, and the FSM state encoding (SCAN=0, BLANK=1).
- Sub-module seg7_hex_decoder: combinational, 4-bit nibble → 7-bit active-high segments. It is instantiated once on the muxed nibble.
- The top holds the buffers, the FSM, the blanking logic and the output registers.

## Test plan
- N_DIGITS=4, CLK_DIV=4, GAP=1, load 0x12AF, dp_in=0 → after commit, digits 0..3 show F,A,2,1: seg active-high 0x71, 0x77, 0x5B, 0x06, each for 4 cycles with a 1-cycle all-off gap; frame period 20.
- Load 0x0007 → digits 3..1 blank and digit 0 shows 0x07. Load 0x0000 with dp_in=4'b0100 → digits 3 blank, digit 2 shows 0 with dp, digit 1 shows 0, digit 0 shows 0.
- Load 0x1111, then load 0x2222 two cycles later, both before the commit → only 2222 is ever displayed; frame_done pulses once per frame.
- Load on the commit cycle → the old value is shown for one more full frame, and the new value appears at the next frame_done.
- Drop enable mid-digit 2, load 0x5555, raise enable → dig inactive while low; after raising, digit 0 is lit 1 cycle later showing 5 (seg 0x6D).
- Assert rst_n low mid-scan (asynchronous, off-edge) → dig, seg and dp go inactive immediately (ACTIVE_LOW=1: all ones); after release, a blank display (zero value) resumes from digit 0.
